// File: rtl/fractional_n_ratio_meter.sv
// Fractional-N divider ratio meter: counts clk cycles across 2^GATE_LOG2 divider
// output periods and reports the average ratio in the divider's int.frac word format.
module fractional_n_ratio_meter #(
  parameter int WIDTH_INTEGER = 10,
  parameter int WIDTH_MODULUS = 16,
  parameter int DATA_WIDTH    = 26,
  parameter int GATE_LOG2     = 4,
  parameter int TIMEOUT       = 1024,
  parameter int CONTINUOUS    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse_in,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  result_error,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  localparam int CW    = WIDTH_INTEGER + GATE_LOG2 + 1;
  localparam int TW    = $clog2(TIMEOUT + 1) + 1;
  localparam int SHIFT = WIDTH_MODULUS - GATE_LOG2;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cyc_cnt;
  logic [GATE_LOG2-1:0] pls_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic                 term, tmo_hit, ovf;
  logic [DATA_WIDTH-1:0] t_word, ratio;

  // Termination outranks both timeout and overflow in the same cycle.
  always_comb begin
    term    = (state == MEASURE) && pulse_in && (pls_cnt == '1);
    tmo_hit = (tmo_cnt == TW'(TIMEOUT)) && !pulse_in;
    ovf     = (state == MEASURE) && (cyc_cnt == '1) && !term;
    t_word  = DATA_WIDTH'(cyc_cnt) + DATA_WIDTH'(1);
    ratio   = (t_word << SHIFT) - (DATA_WIDTH'(1) << WIDTH_MODULUS);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ARM;
      ARM: begin
        if (pulse_in)     state_next = MEASURE;
        else if (tmo_hit) state_next = DONE;
      end
      MEASURE: if (term || ovf || tmo_hit) state_next = DONE;
      DONE:    if (result_ready) state_next = (CONTINUOUS != 0) ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    result_valid = (state == DONE);
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt      <= '0;
      pls_cnt      <= '0;
      tmo_cnt      <= '0;
      result_data  <= '0;
      result_error <= 1'b0;
    end else begin
      case (state)
        ARM: begin
          if (pulse_in) begin
            cyc_cnt <= '0;
            pls_cnt <= '0;
          end
        end
        MEASURE: begin
          cyc_cnt <= cyc_cnt + CW'(1);
          if (pulse_in) pls_cnt <= pls_cnt + GATE_LOG2'(1);
        end
        default: ;
      endcase

      // Timeout counter only runs while waiting on pulses; idle states hold it at zero.
      if (state == ARM || state == MEASURE)
        tmo_cnt <= pulse_in ? '0 : tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;

      if (state != DONE && state_next == DONE) begin
        result_data  <= term ? ratio : '0;
        result_error <= !term;
      end
    end
  end

endmodule

// File: tb/tb_fractional_n_ratio_meter.sv
// Scoreboard bench for fractional_n_ratio_meter: one single-shot instance and one
// continuous instance, each with its own pulse generator, queue and monitor.
module tb_fractional_n_ratio_meter;

  localparam int DW = 26;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_a, pulse_a, start_a, ready_a, err_a, valid_a, busy_a;
  logic rst_c, pulse_c, start_c, ready_c, err_c, valid_c, busy_c;
  logic [DW-1:0] data_a, data_c;

  int n_checks = 0;
  int n_fail   = 0;
  int mode_a   = 0;
  int mode_c   = 0;
  int cyc      = 0;
  int lp_a     = 0;
  int lp_c     = 0;

  exp_t q_a[$];
  exp_t q_c[$];

  fractional_n_ratio_meter #(
    .WIDTH_INTEGER(10), .WIDTH_MODULUS(16), .DATA_WIDTH(DW),
    .GATE_LOG2(4), .TIMEOUT(100), .CONTINUOUS(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .pulse_in(pulse_a), .start(start_a),
    .result_data(data_a), .result_error(err_a), .result_valid(valid_a),
    .result_ready(ready_a), .busy(busy_a)
  );

  fractional_n_ratio_meter #(
    .WIDTH_INTEGER(10), .WIDTH_MODULUS(16), .DATA_WIDTH(DW),
    .GATE_LOG2(4), .TIMEOUT(100), .CONTINUOUS(1)
  ) dut_c (
    .clk(clk), .rst(rst_c), .pulse_in(pulse_c), .start(start_c),
    .result_data(data_c), .result_error(err_c), .result_valid(valid_c),
    .result_ready(ready_c), .busy(busy_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pulse_a) lp_a <= cyc;
    if (pulse_c) lp_c <= cyc;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Pulse generators: mode 0 = silent, 1 = every 10 clk, 2 = alternating 10/11 clk.
  initial begin
    int cnt = 0;
    int per;
    bit alt = 1'b0;
    pulse_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      per = (mode_a == 2 && alt) ? 11 : 10;
      cnt++;
      if (mode_a != 0 && cnt >= per) begin
        pulse_a = 1'b1;
        cnt = 0;
        alt = ~alt;
      end else begin
        pulse_a = 1'b0;
        if (mode_a == 0) cnt = 0;
      end
    end
  end

  initial begin
    int cnt = 0;
    pulse_c = 1'b0;
    forever begin
      @(posedge clk); #1;
      cnt++;
      if (mode_c != 0 && cnt >= 10) begin
        pulse_c = 1'b1;
        cnt = 0;
      end else begin
        pulse_c = 1'b0;
      end
    end
  end

  // Monitor A
  logic pv_a = 1'b0, drop_a = 1'b0, he_a = 1'b0;
  logic [DW-1:0] hd_a = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_a) begin
      pv_a = 1'b0;
      drop_a = 1'b0;
    end else begin
      if (drop_a) begin
        check("a_valid_drop", valid_a, 0);
        drop_a = 1'b0;
      end else if (valid_a) begin
        if (!pv_a) begin
          if (q_a.size() == 0) check("a_unexpected_valid", valid_a, 0);
          else begin
            e = q_a.pop_front();
            check("a_data", data_a, e.data);
            check("a_error", err_a, e.err);
            if (!e.err) check("a_latency", cyc - lp_a, 1);
          end
          hd_a = data_a;
          he_a = err_a;
        end else begin
          check("a_hold_data", data_a, hd_a);
          check("a_hold_err", err_a, he_a);
        end
        if (ready_a) drop_a = 1'b1;
      end
      pv_a = valid_a;
    end
  end

  // Monitor C
  logic pv_c = 1'b0, drop_c = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_c) begin
      pv_c = 1'b0;
      drop_c = 1'b0;
    end else begin
      if (drop_c) begin
        check("c_valid_drop", valid_c, 0);
        check("c_rearm_busy", busy_c, 1);
        drop_c = 1'b0;
      end else if (valid_c) begin
        if (!pv_c) begin
          if (q_c.size() == 0) check("c_unexpected_valid", valid_c, 0);
          else begin
            e = q_c.pop_front();
            check("c_data", data_c, e.data);
            check("c_error", err_c, e.err);
            check("c_latency", cyc - lp_c, 1);
          end
        end
        if (ready_c) drop_c = 1'b1;
      end
      pv_c = valid_c;
    end
  end

  task automatic wait_idle_a(input string name);
    int n = 0;
    while ((busy_a || q_a.size() != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check(name, busy_a, 0);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic run_a();
    int n;
    exp_t e;
    rst_a = 1'b1; start_a = 1'b0; ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_valid", valid_a, 0);
    check("a_rst_error", err_a, 0);
    check("a_rst_data", data_a, 0);
    check("a_rst_busy", busy_a, 0);
    rst_a = 1'b0;

    // Constant 10-cycle period: N = 9.0
    mode_a = 1;
    e.data = 26'h90000; e.err = 1'b0; q_a.push_back(e);
    pulse_start_a();
    wait_idle_a("a_t1_timeout");

    // Alternating 10/11: T = 168, N = 9.5
    mode_a = 2;
    e.data = 26'h98000; e.err = 1'b0; q_a.push_back(e);
    pulse_start_a();
    wait_idle_a("a_t2_timeout");

    // No pulses: timeout after 101 cycles in ARM
    mode_a = 0;
    repeat (15) @(posedge clk);
    #1;
    e.data = '0; e.err = 1'b1; q_a.push_back(e);
    pulse_start_a();
    n = 0;
    while (!valid_a && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_timeout_cycles", n, 101);
    wait_idle_a("a_t3_timeout");

    // Backpressure with pulses continuing during DONE
    mode_a = 1;
    ready_a = 1'b0;
    e.data = 26'h90000; e.err = 1'b0; q_a.push_back(e);
    pulse_start_a();
    n = 0;
    while (!valid_a && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_bp_valid_seen", valid_a, 1);
    repeat (25) @(posedge clk);
    #1;
    check("a_bp_still_valid", valid_a, 1);
    ready_a = 1'b1;
    @(posedge clk); #1;
    ready_a = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("a_bp_idle_after", busy_a, 0);
    ready_a = 1'b1;

    // Reset mid-MEASURE, then a clean measurement
    pulse_start_a();
    repeat (60) @(posedge clk);
    #1;
    check("a_mid_busy", busy_a, 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("a_mrst_busy", busy_a, 0);
    check("a_mrst_valid", valid_a, 0);
    check("a_mrst_error", err_a, 0);
    check("a_mrst_data", data_a, 0);
    rst_a = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("a_mrst_no_result", busy_a, 0);
    e.data = 26'h90000; e.err = 1'b0; q_a.push_back(e);
    pulse_start_a();
    wait_idle_a("a_t5_timeout");
    mode_a = 0;
    check("a_pending", q_a.size(), 0);
  endtask

  task automatic run_c();
    int n;
    exp_t e;
    rst_c = 1'b1; start_c = 1'b0; ready_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("c_rst_busy", busy_c, 0);
    rst_c = 1'b0;
    mode_c = 1;
    for (int i = 0; i < 3; i++) begin
      e.data = 26'h90000; e.err = 1'b0; q_c.push_back(e);
    end
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    n = 0;
    while (q_c.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("c_pending", q_c.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    rst_c = 1'b1;
    mode_c = 0;
    @(posedge clk); #1;
    check("c_final_busy", busy_c, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    fork
      run_a();
      run_c();
    join
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
